// File: rtl/battle_pkg.sv
// Shared encodings and per-attack constants for the battle engine.
package battle_pkg;

    typedef enum logic [1:0] {
        ACT_PUNCH = 2'd0,
        ACT_KICK  = 2'd1,
        ACT_BAT   = 2'd2,
        ACT_SWORD = 2'd3
    } act_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_P_TURN,
        ST_E_TURN,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    // Indexed by act_t: base damage, damage spread, hit threshold.
    localparam logic [7:0] ATK_BASE [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    localparam logic [7:0] ATK_VAR  [4] = '{8'd2,  8'd4,  8'd6,  8'd8};
    localparam logic [7:0] ATK_THR  [4] = '{8'd0,  8'd1,  8'd2,  8'd3};

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/battle_lfsr16.sv
// Free-running 16-bit Galois LFSR; holds SEED while reset is asserted.
module battle_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] r
);
    import battle_pkg::*;

    logic [15:0] r_q, r_d;

    always_comb begin
        r_d = {1'b0, r_q[15:1]};
        if (r_q[0]) r_d = r_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= SEED;
        else      r_q <= r_d;
    end

    assign r = r_q;

endmodule

// File: rtl/battle_engine_core.sv
// Turn-based battle datapath: setup, alternating turns, damage resolution and
// win detection, with actions over valid/ready and LFSR-driven rolls.
module battle_engine_core #(
    parameter int unsigned  HP_W           = 8,
    parameter int unsigned  AMMO_W         = 2,
    parameter int unsigned  PLAYER_HP_BASE = 100,
    parameter int unsigned  PLAYER_HP_LVL  = 150,
    parameter int unsigned  BOSS_HP        = 150,
    parameter int unsigned  ENEMY_HP_MIN   = 50,
    parameter int unsigned  ENEMY_HP_SPAN  = 51,
    parameter int unsigned  BAT_USES       = 3,
    parameter int unsigned  SWORD_USES     = 2,
    parameter logic [15:0]  LFSR_SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              level_up,
    input  logic              boss,
    input  logic              act_valid,
    input  logic [1:0]        act_type,
    output logic              act_ready,
    output logic              turn,
    output logic              busy,
    output logic [HP_W-1:0]   player_hp,
    output logic [HP_W-1:0]   enemy_hp,
    output logic [AMMO_W-1:0] player_bat,
    output logic [AMMO_W-1:0] player_sword,
    output logic [AMMO_W-1:0] enemy_bat,
    output logic [AMMO_W-1:0] enemy_sword,
    output logic              result_valid,
    output logic              result_hit,
    output logic              result_empty,
    output logic [HP_W-1:0]   result_dmg,
    output logic              player_win,
    output logic              enemy_win
);
    import battle_pkg::*;

    logic [15:0] lfsr_r;

    battle_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .r   (lfsr_r)
    );

    state_t              state_q, state_d;
    logic                turn_q, turn_d, lvl_q, lvl_d, boss_q, boss_d;
    logic [HP_W-1:0]     php_q, php_d, ehp_q, ehp_d;
    logic [AMMO_W-1:0]   pbat_q, pbat_d, psw_q, psw_d, ebat_q, ebat_d, esw_q, esw_d;
    logic                rv_q, rv_d, rhit_q, rhit_d, rempty_q, rempty_d;
    logic [HP_W-1:0]     rdmg_q, rdmg_d;
    logic                pwin_q, pwin_d, ewin_q, ewin_d;
    act_t                snap_type_q, snap_type_d;
    logic                snap_side_q, snap_side_d;
    logic [7:0]          snap_r_q, snap_r_d;

    logic                limited, empty, hit;
    logic [AMMO_W-1:0]   ammo_cnt;
    logic [15:0]         roll, spread, dmg16;
    logic [HP_W-1:0]     dmg, target_hp, new_hp;
    logic [31:0]         rand_hp;

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        lvl_d       = lvl_q;
        boss_d      = boss_q;
        php_d       = php_q;
        ehp_d       = ehp_q;
        pbat_d      = pbat_q;
        psw_d       = psw_q;
        ebat_d      = ebat_q;
        esw_d       = esw_q;
        rv_d        = 1'b0;
        rhit_d      = rhit_q;
        rempty_d    = rempty_q;
        rdmg_d      = rdmg_q;
        pwin_d      = pwin_q;
        ewin_d      = ewin_q;
        snap_type_d = snap_type_q;
        snap_side_d = snap_side_q;
        snap_r_d    = snap_r_q;

        // Resolution terms derived purely from the action snapshot.
        limited   = (snap_type_q == ACT_BAT) || (snap_type_q == ACT_SWORD);
        ammo_cnt  = snap_side_q ? (snap_type_q[0] ? esw_q : ebat_q)
                                : (snap_type_q[0] ? psw_q : pbat_q);
        empty     = limited && (ammo_cnt == '0);
        roll      = (16'(snap_r_q[3:0]) * 16'd10) >> 4;
        hit       = !empty && (roll > 16'(ATK_THR[snap_type_q]));
        spread    = 16'(snap_r_q[7:4]) * 16'({ATK_VAR[snap_type_q], 1'b1});
        dmg16     = 16'(ATK_BASE[snap_type_q]) - 16'(ATK_VAR[snap_type_q]) + (spread >> 4);
        dmg       = HP_W'(dmg16);
        target_hp = snap_side_q ? php_q : ehp_q;
        new_hp    = !hit ? target_hp : ((target_hp < dmg) ? '0 : target_hp - dmg);
        rand_hp   = ENEMY_HP_MIN + ((32'(lfsr_r[15:8]) * ENEMY_HP_SPAN) >> 8);

        if (start) begin
            state_d = ST_SETUP;
            lvl_d   = level_up;
            boss_d  = boss;
            pwin_d  = 1'b0;
            ewin_d  = 1'b0;
            turn_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    state_d = ST_P_TURN;
                    php_d   = lvl_q  ? HP_W'(PLAYER_HP_LVL) : HP_W'(PLAYER_HP_BASE);
                    ehp_d   = boss_q ? HP_W'(BOSS_HP) : HP_W'(rand_hp);
                    pbat_d  = AMMO_W'(BAT_USES);
                    psw_d   = AMMO_W'(SWORD_USES);
                    ebat_d  = AMMO_W'(BAT_USES);
                    esw_d   = AMMO_W'(SWORD_USES);
                end
                ST_P_TURN, ST_E_TURN: begin
                    if (act_valid) begin
                        snap_type_d = act_t'(act_type);
                        snap_side_d = turn_q;
                        snap_r_d    = lfsr_r[7:0];
                        state_d     = ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    rv_d     = 1'b1;
                    rhit_d   = hit;
                    rempty_d = empty;
                    rdmg_d   = hit ? dmg : '0;
                    if (limited && !empty) begin
                        case ({snap_side_q, snap_type_q[0]})
                            2'b00:   pbat_d = pbat_q - AMMO_W'(1);
                            2'b01:   psw_d  = psw_q  - AMMO_W'(1);
                            2'b10:   ebat_d = ebat_q - AMMO_W'(1);
                            default: esw_d  = esw_q  - AMMO_W'(1);
                        endcase
                    end
                    if (snap_side_q) php_d = new_hp;
                    else             ehp_d = new_hp;
                    if (new_hp == '0) begin
                        state_d = ST_DONE;
                        if (snap_side_q) ewin_d = 1'b1;
                        else             pwin_d = 1'b1;
                    end else begin
                        state_d = snap_side_q ? ST_P_TURN : ST_E_TURN;
                        turn_d  = ~snap_side_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            turn_q      <= 1'b0;
            lvl_q       <= 1'b0;
            boss_q      <= 1'b0;
            php_q       <= HP_W'(PLAYER_HP_BASE);
            ehp_q       <= '0;
            pbat_q      <= AMMO_W'(BAT_USES);
            psw_q       <= AMMO_W'(SWORD_USES);
            ebat_q      <= AMMO_W'(BAT_USES);
            esw_q       <= AMMO_W'(SWORD_USES);
            rv_q        <= 1'b0;
            rhit_q      <= 1'b0;
            rempty_q    <= 1'b0;
            rdmg_q      <= '0;
            pwin_q      <= 1'b0;
            ewin_q      <= 1'b0;
            snap_type_q <= ACT_PUNCH;
            snap_side_q <= 1'b0;
            snap_r_q    <= '0;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            lvl_q       <= lvl_d;
            boss_q      <= boss_d;
            php_q       <= php_d;
            ehp_q       <= ehp_d;
            pbat_q      <= pbat_d;
            psw_q       <= psw_d;
            ebat_q      <= ebat_d;
            esw_q       <= esw_d;
            rv_q        <= rv_d;
            rhit_q      <= rhit_d;
            rempty_q    <= rempty_d;
            rdmg_q      <= rdmg_d;
            pwin_q      <= pwin_d;
            ewin_q      <= ewin_d;
            snap_type_q <= snap_type_d;
            snap_side_q <= snap_side_d;
            snap_r_q    <= snap_r_d;
        end
    end

    assign act_ready    = (state_q == ST_P_TURN) || (state_q == ST_E_TURN);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign turn         = turn_q;
    assign player_hp    = php_q;
    assign enemy_hp     = ehp_q;
    assign player_bat   = pbat_q;
    assign player_sword = psw_q;
    assign enemy_bat    = ebat_q;
    assign enemy_sword  = esw_q;
    assign result_valid = rv_q;
    assign result_hit   = rhit_q;
    assign result_empty = rempty_q;
    assign result_dmg   = rdmg_q;
    assign player_win   = pwin_q;
    assign enemy_win    = ewin_q;

endmodule

// File: tb/tb_battle_engine_core.sv
// Directed bench for battle_engine_core; rolls predicted by an LFSR model.
module tb_battle_engine_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, level_up = 1'b0, boss = 1'b0, act_valid = 1'b0;
    logic [1:0] act_type = 2'd0;
    logic       act_ready, turn, busy, result_valid, result_hit, result_empty;
    logic       player_win, enemy_win;
    logic [7:0] player_hp, enemy_hp, result_dmg;
    logic [1:0] player_bat, player_sword, enemy_bat, enemy_sword;

    battle_engine_core #(
        .HP_W(8), .AMMO_W(2), .PLAYER_HP_BASE(100), .PLAYER_HP_LVL(150),
        .BOSS_HP(150), .ENEMY_HP_MIN(50), .ENEMY_HP_SPAN(51),
        .BAT_USES(3), .SWORD_USES(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .level_up(level_up), .boss(boss),
        .act_valid(act_valid), .act_type(act_type), .act_ready(act_ready),
        .turn(turn), .busy(busy), .player_hp(player_hp), .enemy_hp(enemy_hp),
        .player_bat(player_bat), .player_sword(player_sword),
        .enemy_bat(enemy_bat), .enemy_sword(enemy_sword),
        .result_valid(result_valid), .result_hit(result_hit),
        .result_empty(result_empty), .result_dmg(result_dmg),
        .player_win(player_win), .enemy_win(enemy_win)
    );

    always #5 clk = ~clk;

    // Reference LFSR: m at a negedge equals the DUT's r for that cycle.
    logic [15:0] m;
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= 16'hACE1;
        else      m <= lfsr_next(m);
    end

    localparam int BASE [4] = '{10, 20, 30, 40};
    localparam int VARS [4] = '{2, 4, 6, 8};
    localparam int THR  [4] = '{0, 1, 2, 3};

    int total = 0, passed = 0, fails = 0;
    int e_php, e_ehp, e_pbat, e_psw, e_ebat, e_esw, e_pwin, e_ewin;

    function automatic int f_roll(input logic [15:0] r);
        return (int'(r[3:0]) * 10) >> 4;
    endfunction
    function automatic int f_dmg(input int t, input logic [15:0] r);
        return BASE[t] - VARS[t] + ((int'(r[7:4]) * (2 * VARS[t] + 1)) >> 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_php"}, player_hp, e_php);
        chk({tag, "_ehp"}, enemy_hp, e_ehp);
        chk({tag, "_pbat"}, player_bat, e_pbat);
        chk({tag, "_psw"}, player_sword, e_psw);
        chk({tag, "_ebat"}, enemy_bat, e_ebat);
        chk({tag, "_esw"}, enemy_sword, e_esw);
        chk({tag, "_pwin"}, player_win, e_pwin);
        chk({tag, "_ewin"}, enemy_win, e_ewin);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_php"}, player_hp, 100);
        chk({tag, "_ehp"}, enemy_hp, 0);
        chk({tag, "_ammo"}, {player_bat, player_sword, enemy_bat, enemy_sword}, 8'b11_10_11_10);
        chk({tag, "_turn"}, turn, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, act_ready, 0);
        chk({tag, "_res"}, {result_valid, result_hit, result_empty}, 0);
        chk({tag, "_dmg"}, result_dmg, 0);
        chk({tag, "_wins"}, {player_win, enemy_win}, 0);
    endtask

    task automatic model_setup(input int lvl, input int bs, input logic [15:0] r);
        e_php  = lvl ? 150 : 100;
        e_ehp  = bs ? 150 : 50 + ((int'(r[15:8]) * 51) >> 8);
        e_pbat = 3; e_psw = 2; e_ebat = 3; e_esw = 2;
        e_pwin = 0; e_ewin = 0;
    endtask

    task automatic model_apply(input int side, input int t, input logic [15:0] r,
                               output int hit, output int empty, output int dmg_out);
        int cnt, tgt, d;
        cnt = 1;
        if (t == 2) cnt = side ? e_ebat : e_pbat;
        if (t == 3) cnt = side ? e_esw : e_psw;
        empty   = (t >= 2 && cnt == 0) ? 1 : 0;
        hit     = (empty == 0 && f_roll(r) > THR[t]) ? 1 : 0;
        d       = f_dmg(t, r);
        dmg_out = hit ? d : 0;
        tgt     = side ? e_php : e_ehp;
        if (hit != 0) tgt = (tgt < d) ? 0 : tgt - d;
        if (side != 0) e_php = tgt; else e_ehp = tgt;
        if (t >= 2 && empty == 0) begin
            if (t == 2 && side == 0) e_pbat--;
            if (t == 2 && side != 0) e_ebat--;
            if (t == 3 && side == 0) e_psw--;
            if (t == 3 && side != 0) e_esw--;
        end
        if (tgt == 0) begin
            if (side != 0) e_ewin = 1; else e_pwin = 1;
        end
    endtask

    // start pulse, then check the reloaded values once in the player's turn
    task automatic do_start(input int lvl, input int bs, input string tag);
        logic [15:0] r;
        start = 1'b1; level_up = lvl[0]; boss = bs[0];
        @(negedge clk);
        start = 1'b0;
        r = m;
        chk({tag, "_setup_busy"}, busy, 1);
        chk({tag, "_setup_ready"}, act_ready, 0);
        @(negedge clk);
        model_setup(lvl, bs, r);
        chk({tag, "_ready"}, act_ready, 1);
        chk({tag, "_turn"}, turn, 0);
    endtask

    // mode 0 any, 1 must hit, 2 hit without killing, 3 must miss
    task automatic act(input int side, input int t, input int mode, input string tag);
        logic [15:0] r;
        int tries, hit, empty, d, tgt, cnt;
        bit ok;
        tries = 0; ok = 1'b0;
        while (!ok && tries < 300) begin
            r = m;
            cnt = 1;
            if (t == 2) cnt = side ? e_ebat : e_pbat;
            if (t == 3) cnt = side ? e_esw : e_psw;
            empty = (t >= 2 && cnt == 0) ? 1 : 0;
            hit   = (empty == 0 && f_roll(r) > THR[t]) ? 1 : 0;
            d     = f_dmg(t, r);
            tgt   = side ? e_php : e_ehp;
            ok = (mode == 0) || (mode == 1 && hit == 1) ||
                 (mode == 2 && hit == 1 && d < tgt) || (mode == 3 && hit == 0);
            if (!ok) begin
                tries++;
                @(negedge clk);
            end
        end
        chk({tag, "_wait"}, ok, 1);
        chk({tag, "_ready"}, act_ready, 1);
        chk({tag, "_turn"}, turn, side);
        r = m;
        act_type = 2'(t); act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        chk({tag, "_resolve_ready"}, act_ready, 0);
        chk({tag, "_resolve_rv"}, result_valid, 0);
        @(negedge clk);
        model_apply(side, t, r, hit, empty, d);
        chk({tag, "_rv"}, result_valid, 1);
        chk({tag, "_hit"}, result_hit, hit);
        chk({tag, "_empty"}, result_empty, empty);
        chk({tag, "_dmg"}, result_dmg, d);
        tgt = side ? e_php : e_ehp;
        if (tgt != 0) chk({tag, "_next_turn"}, turn, 1 - side);
        check_state(tag);
    endtask

    initial begin
        logic [15:0] r0, r2, r4;
        int h, em, d, ph, eh, rounds;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ready", act_ready, 0);

        do_start(1, 1, "setup");
        check_state("setup");

        for (int i = 0; i < 200; i++) begin
            do_start(0, 0, "rand");
            chk("rand_ehp_range", (enemy_hp >= 50 && enemy_hp <= 100) ? 1 : 0, 1);
            chk("rand_ehp_exact", enemy_hp, e_ehp);
        end

        // swords run out on the third use; enemy punches miss to spare the player
        do_start(1, 1, "ammo");
        act(0, 3, 0, "sword1");
        chk("sword1_left", player_sword, 1);
        act(1, 0, 3, "epunch1");
        act(0, 3, 0, "sword2");
        chk("sword2_left", player_sword, 0);
        act(1, 0, 3, "epunch2");
        eh = e_ehp;
        act(0, 3, 0, "sword3");
        chk("sword3_empty", result_empty, 1);
        chk("sword3_dmg", result_dmg, 0);
        chk("sword3_ehp", enemy_hp, eh);
        chk("sword3_turn", turn, 1);

        // whittle the enemy below minimum kick damage, then kick to saturate at 0
        act(1, 0, 3, "epunch3");
        rounds = 0;
        while (e_ehp >= 16 && rounds < 40) begin
            act(0, (e_ehp > 24) ? 1 : 0, 2, "wear");
            act(1, 0, 3, "emiss");
            rounds++;
        end
        chk("wear_bounded", (e_ehp < 16 && e_ehp > 0) ? 1 : 0, 1);
        act(0, 1, 1, "kill");
        chk("kill_ehp", enemy_hp, 0);
        chk("kill_pwin", player_win, 1);
        chk("kill_ewin", enemy_win, 0);
        chk("kill_busy", busy, 0);
        chk("kill_ready", act_ready, 0);
        ph = player_hp;
        act_valid = 1'b1; act_type = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_no_result", result_valid, 0);
        end
        act_valid = 1'b0;
        chk("done_php", player_hp, ph);
        chk("done_ehp", enemy_hp, 0);
        chk("done_pwin", player_win, 1);

        // act_valid held high: one accept per turn, result one cycle later
        start = 1'b1; level_up = 1'b0; boss = 1'b1; act_valid = 1'b1; act_type = 2'd0;
        @(negedge clk);
        start = 1'b0;
        r0 = m;
        chk("hs_setup_ready", act_ready, 0);
        chk("hs_setup_wins", {player_win, enemy_win}, 0);
        @(negedge clk);
        model_setup(0, 1, r0);
        r0 = m;
        chk("hs_c0", {act_ready, turn, result_valid}, 3'b100);
        @(negedge clk);
        chk("hs_c1", {act_ready, turn, result_valid}, 3'b000);
        @(negedge clk);
        model_apply(0, 0, r0, h, em, d);
        r2 = m;
        chk("hs_c2", {act_ready, turn, result_valid}, 3'b111);
        chk("hs_c2_ehp", enemy_hp, e_ehp);
        chk("hs_c2_hit", result_hit, h);
        chk("hs_c2_dmg", result_dmg, d);
        @(negedge clk);
        chk("hs_c3", {act_ready, turn, result_valid}, 3'b010);
        @(negedge clk);
        model_apply(1, 0, r2, h, em, d);
        r4 = m;
        chk("hs_c4", {act_ready, turn, result_valid}, 3'b101);
        chk("hs_c4_php", player_hp, e_php);
        chk("hs_c4_dmg", result_dmg, d);
        @(negedge clk);
        chk("hs_c5", {act_ready, turn, result_valid}, 3'b000);
        @(negedge clk);
        model_apply(0, 0, r4, h, em, d);
        chk("hs_c6", {act_ready, turn, result_valid}, 3'b111);
        chk("hs_c6_ehp", enemy_hp, e_ehp);

        // start during the enemy's turn beats the offered action
        ph = e_php; eh = e_ehp;
        start = 1'b1; level_up = 1'b0; boss = 1'b1;
        @(negedge clk);
        start = 1'b0; act_valid = 1'b0;
        chk("abort_dropped", result_valid, 0);
        chk("abort_php_kept", player_hp, ph);
        chk("abort_ehp_kept", enemy_hp, eh);
        chk("abort_busy", busy, 1);
        @(negedge clk);
        model_setup(0, 1, 16'h0000);
        check_state("abort_reload");
        chk("abort_turn", turn, 0);
        chk("abort_ready", act_ready, 1);

        // reset in the middle of RESOLVE discards the pending kick
        act_type = 2'd1; act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        chk("rstres_ready", act_ready, 0);
        #2 rst = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        chk_reset("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
